conv_event_scheduler: RTL and testbench
=======================================

// Module: conv_event_scheduler
// PURPOSE
// Sequences the convolution core between event capture and the conv datapath. Forwards
// spike events one at a time via a one-entry holding register. On a timestep marker it
// stalls capture, drains in-flight work, then runs one fire/leak pass over the feature map.
// Keeps the timestep counter and a fire-pass watchdog.
// PARAMETERS
// BITS_PER_COORDINATE  8     width of x and y event coordinates
// IN_CHANNELS          4     spike vector width per event
// TS_COUNT_WIDTH       16    width of the completed-timestep counter
// FIRE_TIMEOUT         4096  max cycles from fire_start to fire_done before error
// PORTS
// clk              in   1    system clock
// rst              in   1    synchronous, active-high reset
// enable           in   1    global run enable
// ts_pulse         in   1    1-cycle pulse: capture consumed a timestep word
// evt_valid        in   1    capture has an event on evt_data
// evt_data         in   EW   {x,y,spikes}, EW = 2*BITS_PER_COORDINATE+IN_CHANNELS
// evt_ack          out  1    1-cycle pulse: event accepted
// capture_enable   out  1    permits capture to read its FIFO
// conv_evt_valid   out  1    event held for the conv core
// conv_evt_data    out  EW   held event
// conv_evt_ack     in   1    conv core accepted conv_evt_data
// conv_busy        in   1    conv core is still processing an accepted event
// fire_start       out  1    1-cycle pulse: start fire/leak pass
// fire_done        in   1    1-cycle pulse: fire/leak pass complete
// ts_count         out  TSW  number of completed timesteps (wraps)
// timeout_err      out  1    sticky; set on watchdog expiry
// sched_idle       out  1    IDLE, nothing held, no timestep pending
// BEHAVIOUR
// - Reset: state=IDLE; ts_pending, evt_ack, conv_evt_valid, fire_start, ts_count and
//   timeout_err all 0; conv_evt_data=0; capture_enable=0; watchdog=0.
// - Reset mid-operation discards the held event and any pending timestep.
// - capture_enable = enable & !ts_pending & !conv_evt_valid & state==IDLE.
// - ts_pulse sets ts_pending in any state. ts_pending clears on entry to FIRE_WAIT.
// - Event accept: in IDLE with evt_valid & !conv_evt_valid & !ts_pending & enable:
//   - latch evt_data; register evt_ack=1 for 1 cycle.
//   - conv_evt_valid=1 from the next cycle.
//   - The accept-to-conv_evt_valid latency is 1 cycle.
// - conv_evt_valid & conv_evt_ack clears conv_evt_valid in the same edge. Data is held
//   stable while valid is high.
// - If evt_valid and ts_pulse arrive in the same cycle, the event is accepted first and the
//   timestep is pended.
// - FSM states: IDLE, DRAIN, FIRE_REQ, FIRE_WAIT.
//   - IDLE -> DRAIN when ts_pending & enable.
//   - DRAIN: waits !conv_evt_valid & !conv_busy, then -> FIRE_REQ.
//   - FIRE_REQ: fire_start=1 for exactly 1 cycle, clear ts_pending, -> FIRE_WAIT.
//   - FIRE_WAIT: on fire_done, ts_count++ (modulo 2^TSW) and -> IDLE.
//     A fire_done outside FIRE_WAIT is ignored.
// - Watchdog: counts cycles in FIRE_WAIT and clears otherwise. At FIRE_TIMEOUT-1 it sets
//   timeout_err and forces IDLE with no ts_count increment. Only rst clears timeout_err.
// - enable low: no new accepts and no IDLE->DRAIN. An in-progress DRAIN/FIRE sequence
//   completes, and the held event stays valid until acked.
// - A second ts_pulse while ts_pending is already set merges into the first (one pass).
// - A ts_pulse during FIRE_WAIT re-pends and causes another pass after return to IDLE.
// STRUCTURE
// - conv_pkg additions:
//   - sched_state_t enum.
//   - event_t packed struct {x,y,spikes}, shared with capture.
// - Single module; the watchdog counter is inline. No sub-module is warranted.
// TESTING
// 1. Reset with inputs toggling -> all outputs 0 for the duration of rst and 1 cycle after.
// 2. evt_valid with x=3,y=5,spikes=4'b0101, conv_evt_ack at +3 -> evt_ack pulse at +1;
//    conv_evt_valid on +1..+3 with data held; capture_enable low in between.
// 3. ts_pulse while event held and conv_busy high 4 cycles -> fire_start only after both clear;
//    fire_done -> ts_count 0->1, sched_idle=1.
// 4. evt_valid and ts_pulse same cycle -> event forwarded first, then a single fire_start.
// 5. FIRE_TIMEOUT=16, fire_done never arrives -> timeout_err=1 after 16 FIRE_WAIT cycles,
//    state IDLE, ts_count unchanged.
// 6. TS_COUNT_WIDTH=2, 4 full timesteps -> ts_count wraps 3->0; rst asserted mid-DRAIN ->
//    IDLE, ts_pending=0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: types shared by the convolution-core control blocks.
//   sched_state_t : conv_event_scheduler FSM states
//   event_t       : {x, y, spikes} event word exchanged with capture
package conv_pkg;

  localparam int EVT_COORD_W = 8;
  localparam int EVT_CH_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DRAIN     = 2'd1,
    S_FIRE_REQ  = 2'd2,
    S_FIRE_WAIT = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [EVT_COORD_W-1:0] x;
    logic [EVT_COORD_W-1:0] y;
    logic [EVT_CH_W-1:0]    spikes;
  } event_t;

endpackage

// File: rtl/conv_event_scheduler.sv
// conv_event_scheduler: sits between event capture and the conv datapath.
// Forwards spike events one at a time through a one-entry holding register.
// A timestep marker stalls capture, drains in-flight work, then runs one
// fire/leak pass. Tracks completed timesteps and watches the fire pass.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   enable           global run enable
//   ts_pulse         capture consumed a timestep word (1-cycle pulse)
//   evt_valid/data   event offered by capture, {x,y,spikes}
//   evt_ack          1-cycle accept pulse back to capture
//   capture_enable   capture may read its FIFO
//   conv_evt_*       held event handshake to the conv core
//   conv_busy        conv core still processing an accepted event
//   fire_start/done  fire/leak pass handshake (1-cycle pulses)
//   ts_count         completed timesteps, wraps
//   timeout_err      sticky fire-pass watchdog expiry
//   sched_idle       idle, nothing held, no timestep pending
//
// All outputs are registered, so they sit at 0 through reset and for the
// cycle after it. capture_enable and sched_idle are computed from next-state
// values, which makes them track the state registers with no added lag.
module conv_event_scheduler
  import conv_pkg::*;
#(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int IN_CHANNELS         = 4,
  parameter int TS_COUNT_WIDTH      = 16,
  parameter int FIRE_TIMEOUT        = 4096,
  localparam int EW = 2*BITS_PER_COORDINATE + IN_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      ts_pulse,
  input  logic                      evt_valid,
  input  logic [EW-1:0]             evt_data,
  output logic                      evt_ack,
  output logic                      capture_enable,
  output logic                      conv_evt_valid,
  output logic [EW-1:0]             conv_evt_data,
  input  logic                      conv_evt_ack,
  input  logic                      conv_busy,
  output logic                      fire_start,
  input  logic                      fire_done,
  output logic [TS_COUNT_WIDTH-1:0] ts_count,
  output logic                      timeout_err,
  output logic                      sched_idle
);

  localparam int WDW = (FIRE_TIMEOUT > 2) ? $clog2(FIRE_TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(FIRE_TIMEOUT - 1);

  sched_state_t              state, state_nx;
  logic                      ts_pending, ts_pending_nx;
  logic [WDW-1:0]            wd, wd_nx;
  logic                      accept, cv_nx, err_nx;
  logic [TS_COUNT_WIDTH-1:0] ts_nx;

  always_comb begin
    accept        = (state == S_IDLE) & evt_valid & ~conv_evt_valid & ~ts_pending & enable;
    cv_nx         = conv_evt_valid;
    state_nx      = state;
    ts_pending_nx = ts_pending;
    wd_nx         = '0;
    ts_nx         = ts_count;
    err_nx        = timeout_err;

    if (accept)                              cv_nx = 1'b1;
    else if (conv_evt_valid && conv_evt_ack) cv_nx = 1'b0;

    case (state)
      S_IDLE:      if (ts_pending && enable) state_nx = S_DRAIN;
      // Wait for the held event to be taken and the core to go quiet.
      S_DRAIN:     if (!conv_evt_valid && !conv_busy) state_nx = S_FIRE_REQ;
      S_FIRE_REQ: begin
        state_nx      = S_FIRE_WAIT;
        ts_pending_nx = 1'b0;
      end
      S_FIRE_WAIT: begin
        if (fire_done) begin
          state_nx = S_IDLE;
          ts_nx    = ts_count + 1'b1;
        end else if (wd == WD_LAST) begin
          // Abandon the pass; the timestep is not counted.
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end
      default:     state_nx = S_IDLE;
    endcase

    // A pulse always (re)pends, even on the FIRE_REQ edge, so no marker is lost.
    if (ts_pulse) ts_pending_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ts_pending     <= 1'b0;
      wd             <= '0;
      evt_ack        <= 1'b0;
      conv_evt_valid <= 1'b0;
      conv_evt_data  <= '0;
      fire_start     <= 1'b0;
      ts_count       <= '0;
      timeout_err    <= 1'b0;
      capture_enable <= 1'b0;
      sched_idle     <= 1'b0;
    end else begin
      state          <= state_nx;
      ts_pending     <= ts_pending_nx;
      wd             <= wd_nx;
      evt_ack        <= accept;
      conv_evt_valid <= cv_nx;
      if (accept) conv_evt_data <= evt_data;
      fire_start     <= (state_nx == S_FIRE_REQ);
      ts_count       <= ts_nx;
      timeout_err    <= err_nx;
      capture_enable <= enable & (state_nx == S_IDLE) & ~ts_pending_nx & ~cv_nx;
      sched_idle     <= (state_nx == S_IDLE) & ~ts_pending_nx & ~cv_nx;
    end
  end

endmodule

// File: tb/tb_conv_event_scheduler.sv
module tb_conv_event_scheduler;
  localparam int BPC = 8, INC = 4, TSW = 2, TMO = 16;
  localparam int EW  = 2*BPC + INC;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_REQ = 2, P_WAIT = 3;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, ts_pulse = 1'b0, evt_valid = 1'b0;
  logic conv_evt_ack = 1'b0, conv_busy = 1'b0, fire_done = 1'b0;
  logic [EW-1:0]  evt_data = '0;
  logic           evt_ack, capture_enable, conv_evt_valid, fire_start, timeout_err, sched_idle;
  logic [EW-1:0]  conv_evt_data;
  logic [TSW-1:0] ts_count;

  int compared = 0, mismatched = 0;
  bit started = 0;

  conv_event_scheduler #(
    .BITS_PER_COORDINATE(BPC), .IN_CHANNELS(INC),
    .TS_COUNT_WIDTH(TSW), .FIRE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ts_pulse(ts_pulse),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ack(evt_ack),
    .capture_enable(capture_enable), .conv_evt_valid(conv_evt_valid),
    .conv_evt_data(conv_evt_data), .conv_evt_ack(conv_evt_ack), .conv_busy(conv_busy),
    .fire_start(fire_start), .fire_done(fire_done), .ts_count(ts_count),
    .timeout_err(timeout_err), .sched_idle(sched_idle)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase of the timestep sequence, held event, pending
  // marker, watchdog age, completed count. 'en' is the enable seen at the
  // last edge, 'live' marks that a non-reset edge has occurred.
  typedef struct {
    int phase; bit pend; bit cv; logic [EW-1:0] cd; bit ack;
    int wd; int ts; bit err; bit en; bit live;
  } mdl_t;
  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = P_IDLE; r.pend = 0; r.cv = 0; r.cd = '0; r.ack = 0;
    r.wd = 0; r.ts = 0; r.err = 0; r.en = 0; r.live = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t c, bit en, bit tsp, bit ev, logic [EW-1:0] ed,
                                bit cack, bit busy, bit fdone);
    mdl_t n = c;
    bit take = (c.phase == P_IDLE) && ev && !c.cv && !c.pend && en;
    n.live = 1; n.en = en; n.ack = take; n.wd = 0;
    if (take) begin n.cv = 1; n.cd = ed; end
    else if (c.cv && cack) n.cv = 0;
    if (c.phase == P_IDLE) begin
      if (c.pend && en) n.phase = P_DRAIN;
    end else if (c.phase == P_DRAIN) begin
      if (!c.cv && !busy) n.phase = P_REQ;
    end else if (c.phase == P_REQ) begin
      n.phase = P_WAIT; n.pend = 0;
    end else begin
      if (fdone) begin n.phase = P_IDLE; n.ts = (c.ts + 1) % (1 << TSW); end
      else if (c.wd == TMO - 1) begin n.phase = P_IDLE; n.err = 1; end
      else n.wd = c.wd + 1;
    end
    if (tsp) n.pend = 1;
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) m <= mdl_reset();
    else     m <= step(m, enable, ts_pulse, evt_valid, evt_data, conv_evt_ack, conv_busy, fire_done);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m_evt_ack",   32'(evt_ack),        32'(m.ack));
      chk("m_conv_vld",  32'(conv_evt_valid), 32'(m.cv));
      chk("m_conv_data", 32'(conv_evt_data),  32'(m.cd));
      chk("m_fire",      32'(fire_start),     32'(m.phase == P_REQ));
      chk("m_ts_count",  32'(ts_count),       32'(m.ts));
      chk("m_timeout",   32'(timeout_err),    32'(m.err));
      chk("m_cap_en",    32'(capture_enable),
          32'(m.en && m.phase == P_IDLE && !m.pend && !m.cv));
      chk("m_idle",      32'(sched_idle),
          32'(m.live && m.phase == P_IDLE && !m.pend && !m.cv));
    end
  end

  function automatic logic [7:0] all_outs();
    return {evt_ack, capture_enable, conv_evt_valid, fire_start, timeout_err, sched_idle,
            |conv_evt_data, |ts_count};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fs(input int budget, input string nm);
    int k = 0;
    while (fire_start !== 1'b1 && k < budget) begin tick(); k++; end
    chk(nm, 32'(fire_start), 32'd1);
  endtask

  task automatic count_fs(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin tick(); if (fire_start) cnt++; end
  endtask

  task automatic finish_pass();
    tick(); fire_done = 1;
    tick(); fire_done = 0;
  endtask

  initial begin
    int nfs, n;
    logic [EW-1:0] e2;
    // 1: reset with inputs toggling
    @(posedge clk); started = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      enable = 1; evt_valid = 1; evt_data = EW'(20'hABCDE + i);
      ts_pulse = (i % 2 == 0); fire_done = (i % 2 == 1); conv_busy = 1;
      chk("rst_outs", 32'(all_outs()), 32'd0);
    end
    tick();
    evt_valid = 0; ts_pulse = 0; fire_done = 0; conv_busy = 0; evt_data = '0; rst = 0;
    #1 chk("post_rst_outs", 32'(all_outs()), 32'd0);
    tick();
    chk("post_rst_cap_en", 32'(capture_enable), 32'd1);
    chk("post_rst_idle",   32'(sched_idle),     32'd1);

    // 2: single event, conv ack at +3
    e2 = {8'd3, 8'd5, 4'b0101};
    evt_data = e2; evt_valid = 1;
    tick(); evt_valid = 0;
    chk("t2_ack_p1",  32'(evt_ack), 32'd1);
    chk("t2_vld_p1",  32'(conv_evt_valid), 32'd1);
    chk("t2_data_p1", 32'(conv_evt_data), 32'h03055);
    chk("t2_cap_p1",  32'(capture_enable), 32'd0);
    tick();
    chk("t2_ack_p2",  32'(evt_ack), 32'd0);
    chk("t2_data_p2", 32'(conv_evt_data), 32'h03055);
    tick(); conv_evt_ack = 1;
    chk("t2_vld_p3",  32'(conv_evt_valid), 32'd1);
    chk("t2_cap_p3",  32'(capture_enable), 32'd0);
    tick(); conv_evt_ack = 0;
    chk("t2_vld_p4",  32'(conv_evt_valid), 32'd0);
    chk("t2_cap_p4",  32'(capture_enable), 32'd1);

    // 3: timestep while event held and core busy
    evt_data = {8'd10, 8'd20, 4'b1111}; evt_valid = 1;
    tick(); evt_valid = 0; ts_pulse = 1; conv_busy = 1;
    tick(); ts_pulse = 0;
    chk("t3_cap_pend", 32'(capture_enable), 32'd0);
    for (int i = 0; i < 3; i++) begin tick(); chk("t3_no_fire_busy", 32'(fire_start), 32'd0); end
    conv_evt_ack = 1;
    tick(); conv_evt_ack = 0;
    chk("t3_vld_clr", 32'(conv_evt_valid), 32'd0);
    tick(); chk("t3_no_fire_busy2", 32'(fire_start), 32'd0);
    conv_busy = 0;
    wait_fs(10, "t3_fire");
    chk("t3_vld_at_fire", 32'(conv_evt_valid), 32'd0);
    tick(); chk("t3_fire_1cyc", 32'(fire_start), 32'd0);
    fire_done = 1;
    tick(); fire_done = 0;
    chk("t3_ts", 32'(ts_count), 32'd1);
    chk("t3_idle", 32'(sched_idle), 32'd1);

    // 4: event and timestep in the same cycle
    evt_data = {8'd7, 8'd1, 4'b0011}; evt_valid = 1; ts_pulse = 1;
    tick(); evt_valid = 0; ts_pulse = 0;
    chk("t4_ack", 32'(evt_ack), 32'd1);
    chk("t4_data", 32'(conv_evt_data), 32'h07013);
    conv_evt_ack = 1;
    tick(); conv_evt_ack = 0;
    wait_fs(10, "t4_fire");
    finish_pass();
    count_fs(8, nfs);
    chk("t4_single_fire", 32'(nfs), 32'd0);
    chk("t4_ts", 32'(ts_count), 32'd2);

    // merged pulses: second pulse during DRAIN gives one pass
    ts_pulse = 1; tick(); ts_pulse = 0; tick(); ts_pulse = 1; tick(); ts_pulse = 0;
    wait_fs(10, "merge_fire");
    finish_pass();
    count_fs(8, nfs);
    chk("merge_single_fire", 32'(nfs), 32'd0);
    chk("merge_ts", 32'(ts_count), 32'd3);

    // pulse during FIRE_WAIT re-pends; ts_count wraps 3 -> 0
    ts_pulse = 1; tick(); ts_pulse = 0;
    wait_fs(10, "repend_fire1");
    tick(); ts_pulse = 1;
    tick(); ts_pulse = 0; fire_done = 1;
    tick(); fire_done = 0;
    chk("wrap_ts", 32'(ts_count), 32'd0);
    wait_fs(10, "repend_fire2");
    finish_pass();
    chk("repend_ts", 32'(ts_count), 32'd1);

    // 5: watchdog expiry
    ts_pulse = 1; tick(); ts_pulse = 0;
    wait_fs(10, "t5_fire");
    n = 0;
    while (!timeout_err && n < 40) begin tick(); n++; end
    chk("t5_timeout_cycles", 32'(n), 32'd17);
    chk("t5_ts_same", 32'(ts_count), 32'd1);
    chk("t5_idle", 32'(sched_idle), 32'd1);
    fire_done = 1; tick(); fire_done = 0; tick();
    chk("t5_stray_done", 32'(ts_count), 32'd1);
    chk("t5_sticky", 32'(timeout_err), 32'd1);

    // enable low: no accept
    enable = 0; evt_data = {8'd9, 8'd9, 4'b1001}; evt_valid = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("en_low_no_ack", 32'(evt_ack), 32'd0); end
    evt_valid = 0; enable = 1;
    tick();

    // 6: reset mid-DRAIN
    evt_data = {8'd4, 8'd4, 4'b0100}; evt_valid = 1;
    tick(); evt_valid = 0; ts_pulse = 1;
    tick(); ts_pulse = 0;
    tick(); tick();
    rst = 1; tick(); tick(); rst = 0;
    #1 chk("t6_rst_outs", 32'(all_outs()), 32'd0);
    tick();
    chk("t6_vld", 32'(conv_evt_valid), 32'd0);
    chk("t6_idle", 32'(sched_idle), 32'd1);
    chk("t6_err_clr", 32'(timeout_err), 32'd0);
    count_fs(6, nfs);
    chk("t6_no_fire", 32'(nfs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
